// File: rtl/pix28_capture_pkg.sv
// Shared definitions for the DNN event capture block.
//   CAP_DEPTH / CAP_PTR_W / CAP_CNT_W : FIFO geometry (16 entries, 4-bit
//                                       pointers, 5-bit occupancy 0..16)
//   CAP_TS_W / CAP_ENTRY_W            : timestamp width and packed entry width
//   cap_entry_t                       : {ts, dnn1, dnn0} as stored in the FIFO
//   cap_state_t                       : capture FSM states
package pix28_capture_pkg;

  localparam int CAP_DEPTH   = 16;
  localparam int CAP_PTR_W   = 4;
  localparam int CAP_CNT_W   = 5;
  localparam int CAP_TS_W    = 16;
  localparam int CAP_ENTRY_W = CAP_TS_W + 2;

  typedef struct packed {
    logic [CAP_TS_W-1:0] ts;
    logic                dnn1;
    logic                dnn0;
  } cap_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/capture_fifo.sv
// 16-entry capture FIFO with registered (non fall-through) read port.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous flush; beats same-cycle wr and rd
//   wr, wr_data : write request and entry
//   rd          : read request pulse
//   rd_data     : entry popped by the last accepted read (holds otherwise)
//   rd_valid    : one-cycle pulse qualifying rd_data
//   count       : occupancy 0..16; empty/full derived from it
//   wr_accept   : combinational, high when the write is taken this cycle
//
// Read handshake: a rd pulse is accepted only when count != 0 in that cycle;
// the entry appears on rd_data with rd_valid=1 after the next rising edge.
// rd with an empty FIFO is dropped silently (no bypass from a same-cycle wr).
// A write is taken when not full, or when full and a read is accepted in
// the same cycle (count stays at 16).
module capture_fifo
  import pix28_capture_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [CAP_ENTRY_W-1:0] wr_data,
  input  logic                   rd,
  output logic [CAP_ENTRY_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic [CAP_CNT_W-1:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   wr_accept
);

  logic [CAP_ENTRY_W-1:0] mem [CAP_DEPTH];
  logic [CAP_PTR_W-1:0]   wr_ptr;
  logic [CAP_PTR_W-1:0]   rd_ptr;
  logic                   rd_fire;

  assign empty     = (count == '0);
  assign full      = (count == CAP_CNT_W'(CAP_DEPTH));
  assign rd_fire   = rd && !empty && !clr;
  assign wr_accept = wr && !clr && (!full || rd_fire);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_accept, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dnn_event_capture.sv
// Captures DNN classifier outputs with a timestamp on each transition of an
// asynchronous event toggle and queues them for software readout.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET : clock, synchronous active-high reset
//   enable, clear, n_events  : run control (n_events = 0 means unlimited)
//   dn_event_toggle          : async event strobe, every edge is one event
//   dnn_output_0/1           : async classifier outputs
//   rd_req / rd_data / rd_valid : FIFO pop interface (see capture_fifo)
//   fifo_count, fifo_empty, fifo_full : FIFO status
//   overflow, drop_count     : sticky drop flag and saturating drop count
//   busy, done               : registered FSM status
//   fsm_state                : raw FSM state for observation
module dnn_event_capture
  import pix28_capture_pkg::*;
(
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [7:0]             n_events,
  input  logic                   dn_event_toggle,
  input  logic                   dnn_output_0,
  input  logic                   dnn_output_1,
  input  logic                   rd_req,
  output logic [CAP_ENTRY_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic [CAP_CNT_W-1:0]   fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             fsm_state
);

  cap_state_t          state;
  logic [CAP_TS_W-1:0] ts;
  logic [7:0]          acc_cnt;
  logic [7:0]          acc_next;
  logic                tog_s1, tog_s2, tog_s3;
  logic                d0_s1, d0_s2, d1_s1, d1_s2;
  logic                ev_pulse;
  logic                stage_valid;
  cap_entry_t          stage_entry;
  logic                in_run;
  logic                wr;
  logic                wr_accept;
  logic                hit_limit;
  logic                drop;

  assign fsm_state = state;
  assign in_run    = (state == ST_RUN);
  assign ev_pulse  = tog_s2 ^ tog_s3;
  // Gating at write time too keeps a staged event from landing after the
  // run has finished or been stopped.
  assign wr        = stage_valid && in_run;
  assign acc_next  = acc_cnt + 8'd1;
  assign hit_limit = wr_accept && (n_events != 8'd0) && (acc_next == n_events);
  assign drop      = wr && !wr_accept && !clear;

  // Synchronizers keep tracking in every state so no stale edge is seen
  // when a run starts.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      {tog_s1, tog_s2, tog_s3} <= 3'b000;
      {d0_s1, d0_s2, d1_s1, d1_s2} <= 4'b0000;
    end else begin
      tog_s1 <= dn_event_toggle;
      tog_s2 <= tog_s1;
      tog_s3 <= tog_s2;
      d0_s1  <= dnn_output_0;
      d0_s2  <= d0_s1;
      d1_s1  <= dnn_output_1;
      d1_s2  <= d1_s1;
    end
  end

  // Entry is sampled during the pulse cycle and written on the next edge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || clear) begin
      stage_valid <= 1'b0;
      stage_entry <= '0;
    end else begin
      stage_valid <= ev_pulse && in_run;
      stage_entry <= '{ts: ts, dnn1: d1_s2, dnn0: d0_s2};
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET || clear) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // FSM, timestamp and accepted-event counter; clear leaves the state alone.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ts      <= '0;
      acc_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            ts      <= '0;
            acc_cnt <= 8'd0;
          end
        end
        ST_RUN: begin
          ts <= ts + 1'b1;
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (hit_limit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
      if (wr_accept) acc_cnt <= acc_next;
      if (clear) begin
        ts      <= '0;
        acc_cnt <= 8'd0;
      end
    end
  end

  capture_fifo u_fifo (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .clr       (clear),
    .wr        (wr),
    .wr_data   (stage_entry),
    .rd        (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .wr_accept (wr_accept)
  );

endmodule

// File: tb/tb_dnn_event_capture.sv
// Bench for dnn_event_capture: scripted runs with a scoreboard of expected
// FIFO entries, compared as rd_valid pulses come out.
module tb_dnn_event_capture;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [7:0]  n_events;
  logic        dn_event_toggle;
  logic        dnn_output_0;
  logic        dnn_output_1;
  logic        rd_req;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c_run  = 0;
  int rv_cnt = 0;
  logic [17:0] exp_q[$];

  dnn_event_capture dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESET    (rst),
    .enable          (enable),
    .clear           (clear),
    .n_events        (n_events),
    .dn_event_toggle (dn_event_toggle),
    .dnn_output_0    (dnn_output_0),
    .dnn_output_1    (dnn_output_1),
    .rd_req          (rd_req),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .fifo_count      (fifo_count),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .busy            (busy),
    .done            (done),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rd_valid pulse pops one expected entry.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rv_cnt++;
      if (exp_q.size() == 0) check_eq("rd_unexpected", 32'd1, 32'd0);
      else check_eq("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  // Entry timestamp = ts in the pulse cycle: two edges after the drive point.
  task automatic drive_event(input logic [1:0] d, input bit accept);
    logic [15:0] t;
    dnn_output_1    = d[1];
    dnn_output_0    = d[0];
    dn_event_toggle = ~dn_event_toggle;
    t = 16'(cyc - c_run + 2);
    if (accept) exp_q.push_back({t, d});
  endtask

  task automatic event_gap(input logic [1:0] d, input bit accept);
    drive_event(d, accept);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reads(input int n);
    rd_req = 1'b1;
    repeat (n) @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_count(input logic [4:0] n, input string tag);
    int k;
    k = 0;
    while (fifo_count !== n && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(fifo_count), 32'(n));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    c_run = cyc + 1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
    check_eq({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({pfx, "_count"}, 32'(fifo_count), 32'd0);
    check_eq({pfx, "_empty"}, 32'(fifo_empty), 32'd1);
    check_eq({pfx, "_full"}, 32'(fifo_full), 32'd0);
    check_eq({pfx, "_ovf"}, 32'(overflow), 32'd0);
    check_eq({pfx, "_drops"}, 32'(drop_count), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv0;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; n_events = 8'd0;
    dn_event_toggle = 1'b0; dnn_output_0 = 1'b0; dnn_output_1 = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Three events, unlimited run, with exact write latency.
    enable = 1'b1; c_run = cyc + 1;
    @(negedge clk);
    check_eq("busy_run", 32'(busy), 32'd1);
    drive_event(2'b01, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("lat_pre", 32'(fifo_count), 32'd0);
    @(negedge clk);
    check_eq("lat_write", 32'(fifo_count), 32'd1);
    event_gap(2'b10, 1'b1);
    event_gap(2'b11, 1'b1);
    wait_count(5'd3, "three_cnt");
    do_reads(3);
    check_eq("three_empty", 32'(fifo_empty), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("stop_busy", 32'(busy), 32'd0);

    // n_events = 4 with six toggles.
    n_events = 8'd4; enable = 1'b1; c_run = cyc + 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) event_gap(2'($urandom_range(0, 3)), i < 4);
    repeat (6) @(negedge clk);
    check_eq("lim_cnt", 32'(fifo_count), 32'd4);
    check_eq("lim_done", 32'(done), 32'd1);
    check_eq("lim_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check_eq("lim_idle", 32'(fsm_state), 32'd0);
    check_eq("lim_done_clr", 32'(done), 32'd0);
    do_reads(4);

    // Overflow: 20 toggles, no reads.
    n_events = 8'd0; enable = 1'b1; c_run = cyc + 1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) event_gap(2'($urandom_range(0, 3)), i < 16);
    repeat (6) @(negedge clk);
    check_eq("ovf_full", 32'(fifo_full), 32'd1);
    check_eq("ovf_cnt", 32'(fifo_count), 32'd16);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drops", 32'(drop_count), 32'd4);
    rv0 = rv_cnt;
    do_reads(16);
    check_eq("drain_pulses", 32'(rv_cnt - rv0), 32'd16);
    check_eq("drain_empty", 32'(fifo_empty), 32'd1);

    // Same-cycle write and read, full then empty.
    pulse_clear();
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_drops", 32'(drop_count), 32'd0);
    for (int i = 0; i < 16; i++) event_gap(2'($urandom_range(0, 3)), 1'b1);
    wait_count(5'd16, "fill16");
    drive_event(2'b10, 1'b1);
    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("simul_full_cnt", 32'(fifo_count), 32'd16);
    check_eq("simul_full_ovf", 32'(overflow), 32'd0);
    do_reads(16);
    rv0 = rv_cnt;
    drive_event(2'b01, 1'b1);
    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("simul_empty_rv", 32'(rv_cnt - rv0), 32'd0);
    check_eq("simul_empty_cnt", 32'(fifo_count), 32'd1);
    do_reads(1);

    // Timestamp wrap at 0xFFFF -> 0x0000.
    pulse_clear();
    while (cyc < c_run + 65533) @(negedge clk);
    drive_event(2'b01, 1'b1);
    @(negedge clk);
    drive_event(2'b10, 1'b1);
    wait_count(5'd2, "wrap_cnt");
    do_reads(2);

    // Clear beats a pending write and a same-cycle read.
    for (int i = 0; i < 17; i++) event_gap(2'($urandom_range(0, 3)), i < 16);
    repeat (5) @(negedge clk);
    check_eq("pre_clr_ovf", 32'(overflow), 32'd1);
    drive_event(2'b11, 1'b0);
    repeat (3) @(negedge clk);
    rv0 = rv_cnt;
    rd_req = 1'b1;
    pulse_clear();
    rd_req = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("clr_cnt", 32'(fifo_count), 32'd0);
    check_eq("clr_ovf2", 32'(overflow), 32'd0);
    check_eq("clr_drops2", 32'(drop_count), 32'd0);
    check_eq("clr_full", 32'(fifo_full), 32'd0);
    check_eq("clr_rv", 32'(rv_cnt - rv0), 32'd0);
    check_eq("clr_state", 32'(fsm_state), 32'd1);
    event_gap(2'b10, 1'b1);
    wait_count(5'd1, "post_clr_cnt");
    do_reads(1);

    // Reset mid-run with five entries queued and one in flight.
    for (int i = 0; i < 5; i++) event_gap(2'($urandom_range(0, 3)), 1'b1);
    wait_count(5'd5, "five_cnt");
    drive_event(2'b01, 1'b0);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("midrun");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("post_rst_cnt", 32'(fifo_count), 32'd0);
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
